// File: rtl/alu_6ops.sv
// ============================================================================
// alu_6ops : registered 32-bit ALU (add/sub/and/or/srl/sra), 1-cycle latency
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_6ops (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALUOp,
  output logic [31:0] C,
  output logic        out_valid,
  output logic        zero,
  output logic        overflow
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SRL = 3'd4;
  localparam logic [2:0] OP_SRA = 3'd5;

  logic [31:0] c_d, c_q;
  logic        ovf_d, ovf_q;
  logic        zero_q, valid_q;
  logic [4:0]  shamt;

  assign shamt = B[4:0];

  always_comb begin
    c_d   = 32'd0;
    ovf_d = 1'b0;
    case (ALUOp)
      OP_ADD: begin
        c_d   = A + B;
        ovf_d = (A[31] == B[31]) && (c_d[31] != A[31]);
      end
      OP_SUB: begin
        c_d   = A - B;
        ovf_d = (A[31] != B[31]) && (c_d[31] != A[31]);
      end
      OP_AND:  c_d = A & B;
      OP_OR:   c_d = A | B;
      OP_SRL:  c_d = A >> shamt;
      OP_SRA:  c_d = $unsigned($signed(A) >>> shamt);
      default: begin
        c_d   = 32'd0;
        ovf_d = 1'b0;
      end
    endcase
  end

  // Result and flags hold when no operation is accepted; valid is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q     <= 32'd0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        c_q    <= c_d;
        ovf_q  <= ovf_d;
        zero_q <= (c_d == 32'd0);
      end
    end
  end

  assign C         = c_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign out_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_6ops.sv
// ============================================================================
// tb_alu_6ops : directed vectors against a behavioural ALU model
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_6ops;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [2:0]  ALUOp = 3'd0;
  logic [31:0] C;
  logic        out_valid, zero, overflow;

  int n_tests = 0;
  int n_fail  = 0;

  alu_6ops dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(A), .B(B), .ALUOp(ALUOp),
    .C(C), .out_valid(out_valid), .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Behavioural model: signed overflow judged by whether the true sum leaves the 32-bit range.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    longint sa, sb, r;
    logic [31:0] c;
    logic o;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 32'd0;
    o = 1'b0;
    case (op)
      3'd0: begin r = sa + sb; c = r[31:0]; o = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      3'd1: begin r = sa - sb; c = r[31:0]; o = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      3'd2: c = a & b;
      3'd3: c = a | b;
      3'd4: c = a >> (b % 32);
      3'd5: begin r = sa >>> (b % 32); c = r[31:0]; end
      default: c = 32'd0;
    endcase
    return {o, c};
  endfunction

  logic [31:0] exp_c = 32'd0;
  logic        exp_v = 1'b0, exp_z = 1'b0, exp_o = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_c <= 32'd0; exp_v <= 1'b0; exp_z <= 1'b0; exp_o <= 1'b0;
    end else begin
      exp_v <= in_valid;
      if (in_valid) begin
        {exp_o, exp_c} <= model(A, B, ALUOp);
        exp_z <= (model(A, B, ALUOp) & 33'h0FFFFFFFF) == 33'd0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_C", C, exp_c);
    chk("model_out_valid", {31'd0, out_valid}, {31'd0, exp_v});
    chk("model_zero", {31'd0, zero}, {31'd0, exp_z});
    chk("model_overflow", {31'd0, overflow}, {31'd0, exp_o});
  end

  // Drive one cycle of inputs, then settle just past the following negedge.
  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic v);
    A = a; B = b; ALUOp = op; in_valid = v;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] c, input logic v,
                     input logic z, input logic o);
    chk({name, "_C"}, C, c);
    chk({name, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({name, "_zero"}, {31'd0, zero}, {31'd0, z});
    chk({name, "_ovf"}, {31'd0, overflow}, {31'd0, o});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] sweep_c [6];
  logic        sweep_z [6];

  initial begin
    sweep_c = '{32'd23, 32'hFFFFFFF7, 32'd0, 32'd23, 32'd0, 32'd0};
    sweep_z = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset held with traffic toggling
    for (int i = 0; i < 4; i++) begin
      step(32'h5 + i, 32'hA0 ^ i, 3'd0, 1'b1);
      lit("reset_hold", 32'd0, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    step(32'd7, 32'd16, 3'd0, 1'b1);
    lit("first_add", 32'd23, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      step(32'd7, 32'd16, 3'(i), 1'b1);
      lit($sformatf("sweep_op%0d", i), sweep_c[i], 1'b1, sweep_z[i], 1'b0);
    end

    step(32'h80000000, 32'd4, 3'd4, 1'b1);
    lit("srl4", 32'h08000000, 1'b1, 1'b0, 1'b0);
    step(32'h80000000, 32'd4, 3'd5, 1'b1);
    lit("sra4", 32'hF8000000, 1'b1, 1'b0, 1'b0);
    step(32'h80000000, 32'h24, 3'd4, 1'b1);
    lit("srl_b24", 32'h08000000, 1'b1, 1'b0, 1'b0);
    step(32'h80000000, 32'h24, 3'd5, 1'b1);
    lit("sra_b24", 32'hF8000000, 1'b1, 1'b0, 1'b0);
    step(32'h12345678, 32'd32, 3'd4, 1'b1);
    lit("srl_b32", 32'h12345678, 1'b1, 1'b0, 1'b0);

    step(32'h7FFFFFFF, 32'd1, 3'd0, 1'b1);
    lit("add_ovf", 32'h80000000, 1'b1, 1'b0, 1'b1);
    step(32'h80000000, 32'd1, 3'd1, 1'b1);
    lit("sub_ovf", 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1);
    step(32'hFFFFFFFF, 32'd1, 3'd0, 1'b1);
    lit("add_wrap", 32'd0, 1'b1, 1'b1, 1'b0);
    step(32'h00000005, 32'h80000000, 3'd1, 1'b1);
    lit("sub_ovf2", 32'h80000005, 1'b1, 1'b0, 1'b1);

    // Hold: produce an overflowing result, then idle with changed inputs
    step(32'h7FFFFFFF, 32'h7FFFFFFF, 3'd0, 1'b1);
    lit("pre_hold", 32'hFFFFFFFE, 1'b1, 1'b0, 1'b1);
    step(32'h0, 32'h0, 3'd2, 1'b0);
    lit("hold1", 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1);
    step(32'h1, 32'h1, 3'd3, 1'b0);
    lit("hold2", 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1);

    step(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd6, 1'b1);
    lit("op6", 32'd0, 1'b1, 1'b1, 1'b0);
    step(32'h7FFFFFFF, 32'd1, 3'd7, 1'b1);
    lit("op7", 32'd0, 1'b1, 1'b1, 1'b0);

    // Async reset mid-stream
    step(32'd100, 32'd1, 3'd1, 1'b1);
    lit("pre_rst", 32'd99, 1'b1, 1'b0, 1'b0);
    A = 32'h7FFFFFFF; B = 32'd1; ALUOp = 3'd0; in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    lit("async_rst", 32'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lit("rst_lost_op", 32'd0, 1'b0, 1'b0, 1'b0);
    step(32'd3, 32'd4, 3'd3, 1'b1);
    lit("resume", 32'd7, 1'b1, 1'b0, 1'b0);
    step(32'd3, 32'd4, 3'd3, 1'b0);
    lit("resume_idle", 32'd7, 1'b0, 1'b0, 1'b0);

    // Pin the model itself
    chk("model_add_ovf", model(32'h7FFFFFFF, 32'd1, 3'd0) >> 32, 32'd1);
    chk("model_sra", model(32'h80000000, 32'd4, 3'd5) & 33'h0FFFFFFFF, 32'hF8000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
